freq_meter: RTL and testbench
=============================

# freq_meter

Digital frequency meter that closes the loop around the VCO: it takes the VCO's asynchronous oscillator output and converts its frequency back into an 8-bit code. The meter counts rising edges of the synchronized oscillator over a fixed gate of `i_clk` cycles. It reports the count with a one-cycle valid strobe and an overflow flag. It sits between the VCO output pin and the control logic that computes the next VCO control word.

## Interface
- `GATE_CYCLES`, default 1024: gate length in `i_clk` cycles; must be ≥2.
- `SYNC_STAGES`, default 2: flip-flops in the `i_osc` synchronizer; must be ≥2.
- `i_clk`, input, 1: system clock.
- `i_reset_n`, input, 1: reset, synchronous, active-low, sampled on the rising edge of `i_clk`.
- `i_osc`, input, 1: oscillator under measurement, asynchronous to `i_clk`.
- `i_start`, input, 1: level-sampled request to begin one measurement.
- `o_busy`, output, 1: high while in GATE or DONE.
- `o_data`, output, 8: last measured edge count, saturated at 255.
- `o_valid`, output, 1: one-cycle pulse when `o_data`/`o_overflow` update.
- `o_overflow`, output, 1: last measurement exceeded 255 edges.

## Operation
- `i_osc` passes through `SYNC_STAGES` flops, then a rising-edge detector: `edge = s & ~s_d`.
- The synchronizer and detector run every cycle regardless of state, so a level already high at gate entry never produces an edge.
- The edge counter is `$clog2(GATE_CYCLES)+1` bits wide and never wraps. The gate counter counts 0 to `GATE_CYCLES-1`.
- FSM states and transitions:
  - IDLE: on `i_start`=1, go to GATE; clear the edge counter and gate counter.
  - GATE: increment the edge counter on each cycle with `edge`=1. When the gate counter reaches `GATE_CYCLES-1`, go to DONE. The edge from that last cycle is included.
  - DONE: `o_data` = (count > 255) ? 8'hFF : count[7:0]. `o_overflow` = (count > 255). `o_valid` = 1. Then go to IDLE (see Configuration).
- `i_start` is ignored in GATE and DONE. There is no queueing.
- `o_data` and `o_overflow` hold their values until the next DONE.
- Reset values: `o_data`=0, `o_valid`=0, `o_overflow`=0, `o_busy`=0. State = IDLE; synchronizer, detector and counters = 0.
- Reset mid-GATE or in DONE aborts the measurement. No `o_valid` is produced and all outputs return to their reset values on the next edge.
- Frequency relation: count ≈ f_osc·`GATE_CYCLES`/f_clk, ±1 edge from phase quantization. Valid only for f_osc < f_clk/2.

## Timing
- `i_start` is sampled high at edge N. GATE covers cycles N+1 to N+`GATE_CYCLES`. `o_valid` is high for exactly cycle N+`GATE_CYCLES`+1.
- `o_busy` rises the cycle after `i_start` is sampled. It falls the cycle after DONE (one-shot mode).
- Input latency: an `i_osc` rising edge is counted `SYNC_STAGES`+1 cycles after it is captured by the first flop. Edges in the last `SYNC_STAGES`+1 cycles before the gate ends fall into the next window (continuous mode) or are lost (one-shot mode).
- Back-to-back measurements in one-shot mode: the earliest new start is accepted on the cycle IDLE is re-entered, giving a period of `GATE_CYCLES`+2.

## Configuration
- `FREQ_METER_CONTINUOUS_EN` defined:
  - DONE transitions directly to GATE, clearing both counters.
  - After the first `i_start`, `o_valid` pulses every `GATE_CYCLES`+1 cycles and `o_busy` stays 1 until reset.
  - `i_start` is then ignored.
- Not defined: one-shot mode; DONE always transitions to IDLE.

## Structure
- Shared package `freq_meter_pkg`: FSM state encodings (IDLE=2'd0, GATE=2'd1, DONE=2'd2) and the saturation constant 8'hFF.
- Sub-module `sync_edge_detect`:
  - parameter `SYNC_STAGES`
  - ports `i_clk`, `i_reset_n`, `i_async`, `o_level`, `o_rise`
  - reused by later blocks that sample VCO outputs.

## Test plan
1. Reset held for 5 cycles with `i_osc` toggling → all outputs 0 and `o_busy`=0 throughout.
2. `GATE_CYCLES`=1024, `i_osc` period 40 clk at arbitrary phase, one `i_start` pulse → `o_valid` exactly at start+1025, `o_data` ∈ {25,26}, `o_overflow`=0.
3. `i_osc` period 3 clk (about 341 edges) → `o_data`=8'hFF, `o_overflow`=1. A following run at period 40 clears `o_overflow` to 0.
4. `i_osc` held high before and during the gate → `o_data`=0. `i_osc` held low → `o_data`=0.
5. Reset asserted at gate cycle 500 → no `o_valid`, outputs 0. A fresh `i_start` then completes normally with the case-2 result.
6. `i_start` re-asserted during GATE → ignored, a single `o_valid`. With `FREQ_METER_CONTINUOUS_EN`, consecutive `o_valid` pulses exactly 1025 cycles apart.

Source files
------------

// File: rtl/freq_meter_pkg.sv
// Shared types and constants for the frequency meter: FSM encoding and the
// saturation helpers that turn a raw edge count into the 8-bit result code.
package freq_meter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GATE = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [7:0]  SAT_CODE  = 8'hFF;
    localparam logic [31:0] SAT_LIMIT = 32'd255;

    function automatic logic is_over(input logic [31:0] cnt);
        return (cnt > SAT_LIMIT);
    endfunction

    function automatic logic [7:0] sat_code(input logic [31:0] cnt);
        logic [7:0] code;
        if (cnt > SAT_LIMIT) begin
            code = SAT_CODE;
        end else begin
            code = cnt[7:0];
        end
        return code;
    endfunction

endpackage

// File: rtl/freq_meter_sync_edge_detect.sv
// Multi-flop synchronizer for an asynchronous input followed by a registered
// rising-edge detector; shared by blocks that sample VCO outputs.
module sync_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_async,
    output logic o_level,
    output logic o_rise
);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   level_d_r;
    logic                   rise_r;

    // Synchronizer chain, delayed level and registered rise strobe
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            sync_r    <= {SYNC_STAGES{1'b0}};
            level_d_r <= 1'b0;
            rise_r    <= 1'b0;
        end else begin
            sync_r    <= {sync_r[SYNC_STAGES-2:0], i_async};
            level_d_r <= sync_r[SYNC_STAGES-1];
            rise_r    <= sync_r[SYNC_STAGES-1] & ~level_d_r;
        end
    end

    assign o_level = level_d_r;
    assign o_rise  = rise_r;

endmodule

// File: rtl/freq_meter.sv
// Gated edge-counting frequency meter for the VCO feedback path.
// Define FREQ_METER_CONTINUOUS_EN for free-running back-to-back windows.
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int GATE_CYCLES = 1024,
    parameter int SYNC_STAGES = 2
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_osc,
    input  logic       i_start,
    output logic       o_busy,
    output logic [7:0] o_data,
    output logic       o_valid,
    output logic       o_overflow
);

    localparam int CW = $clog2(GATE_CYCLES) + 1;
    localparam int GW = $clog2(GATE_CYCLES);
    localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);

    state_e          state_r;
    state_e          state_nx_s;
    logic [CW-1:0]   edge_cnt_r;
    logic [CW-1:0]   edge_sum_s;
    logic [GW-1:0]   gate_cnt_r;
    logic            gate_end_s;
    logic            osc_rise_s;
    logic            busy_r;
    logic            valid_r;
    logic            overflow_r;
    logic [7:0]      data_r;

    sync_edge_detect #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_async   (i_osc),
        .o_level   (),
        .o_rise    (osc_rise_s)
    );

    // Count including the current cycle's edge, so the last gate cycle is kept
    assign edge_sum_s = edge_cnt_r + {{(CW-1){1'b0}}, osc_rise_s};
    assign gate_end_s = (gate_cnt_r == GATE_LAST);

    // State register
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state decode
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (i_start) begin
                    state_nx_s = ST_GATE;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_GATE: begin
                if (gate_end_s) begin
                    state_nx_s = ST_DONE;
                end else begin
                    state_nx_s = ST_GATE;
                end
            end
            ST_DONE: begin
`ifdef FREQ_METER_CONTINUOUS_EN
                state_nx_s = ST_GATE;
`else
                state_nx_s = ST_IDLE;
`endif
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // Counters and registered result outputs
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            edge_cnt_r <= {CW{1'b0}};
            gate_cnt_r <= {GW{1'b0}};
            busy_r     <= 1'b0;
            valid_r    <= 1'b0;
            overflow_r <= 1'b0;
            data_r     <= 8'd0;
        end else begin
            valid_r <= 1'b0;
            busy_r  <= (state_nx_s != ST_IDLE);
            case (state_r)
                ST_IDLE: begin
                    if (i_start) begin
                        edge_cnt_r <= {CW{1'b0}};
                        gate_cnt_r <= {GW{1'b0}};
                    end
                end
                ST_GATE: begin
                    edge_cnt_r <= edge_sum_s;
                    if (gate_end_s) begin
                        data_r     <= sat_code(32'(edge_sum_s));
                        overflow_r <= is_over(32'(edge_sum_s));
                        valid_r    <= 1'b1;
                    end else begin
                        gate_cnt_r <= gate_cnt_r + {{(GW-1){1'b0}}, 1'b1};
                    end
                end
                ST_DONE: begin
`ifdef FREQ_METER_CONTINUOUS_EN
                    // Seed with this cycle's edge so nothing falls between windows
                    edge_cnt_r <= {{(CW-1){1'b0}}, osc_rise_s};
                    gate_cnt_r <= {GW{1'b0}};
`endif
                end
                default: begin
                    edge_cnt_r <= {CW{1'b0}};
                    gate_cnt_r <= {GW{1'b0}};
                end
            endcase
        end
    end

    assign o_busy     = busy_r;
    assign o_valid    = valid_r;
    assign o_overflow = overflow_r;
    assign o_data     = data_r;

endmodule

// File: tb/tb_freq_meter.sv
// Scoreboard bench for freq_meter: directed runs push expected results, a
// negedge monitor pops and compares on every o_valid pulse.
module tb_freq_meter;

    localparam int G = 1024;

    typedef struct {
        int cyc;
        int lo;
        int hi;
        int ovf;
    } exp_t;

    logic       clk;
    logic       reset_n;
    logic       osc;
    logic       start;
    logic       busy;
    logic [7:0] data;
    logic       valid;
    logic       ovf;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   osc_mode = 0;
    int   osc_half = 200;
    exp_t q[$];

    freq_meter #(
        .GATE_CYCLES (G),
        .SYNC_STAGES (2)
    ) dut (
        .i_clk      (clk),
        .i_reset_n  (reset_n),
        .i_osc      (osc),
        .i_start    (start),
        .o_busy     (busy),
        .o_data     (data),
        .o_valid    (valid),
        .o_overflow (ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Oscillator: mode 0 toggles with half-period osc_half ns, 1 holds high, 2 holds low
    initial begin
        osc = 1'b0;
        #3;
        forever begin
            if (osc_mode == 0) begin
                osc = 1'b1;
                #(osc_half);
                osc = 1'b0;
                #(osc_half);
            end else begin
                osc = (osc_mode == 1);
                #7;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d..%0d (cycle %0d)", name, act, lo, hi, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (valid === 1'b1) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got o_valid=1 at cycle %0d, expected no pulse", cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("valid_cycle", cyc, e.cyc);
                chk_range("data", int'(data), e.lo, e.hi);
                chk("overflow", int'(ovf), e.ovf);
            end
        end
    end

    task automatic do_start(input bit push, input int lo, input int hi, input int exp_ovf);
        exp_t e;
        @(negedge clk);
        start = 1'b1;
        if (push) begin
            e.cyc = cyc + 1 + G;
            e.lo  = lo;
            e.hi  = hi;
            e.ovf = exp_ovf;
            q.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_drain(input int max_cycles);
        int n = 0;
        while (q.size() != 0 && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL valid_timeout: got %0d pending results after %0d cycles, expected 0", q.size(), n);
            q.delete();
        end
    endtask

    task automatic run(input int lo, input int hi, input int exp_ovf);
        do_start(1'b1, lo, hi, exp_ovf);
        repeat (10) @(negedge clk);
        chk("busy_in_gate", int'(busy), 1);
        wait_drain(G + 20);
        repeat (3) @(negedge clk);
        chk("busy_after", int'(busy), 0);
    endtask

    task automatic chk_reset_outputs(input string name);
        chk(name, int'({busy, valid, ovf, data}), 0);
    endtask

    initial begin
        reset_n = 1'b0;
        start   = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk_reset_outputs("reset_outputs");
        end
        reset_n = 1'b1;
        repeat (3) @(negedge clk);

`ifdef FREQ_METER_CONTINUOUS_EN
        begin
            exp_t e;
            int   n0;
            do_start(1'b1, 25, 26, 0);
            n0 = q[0].cyc;
            for (int k = 1; k < 3; k++) begin
                e.cyc = n0 + k * (G + 1);
                e.lo  = 25;
                e.hi  = 26;
                e.ovf = 0;
                q.push_back(e);
            end
            repeat (10) @(negedge clk);
            chk("busy_continuous", int'(busy), 1);
            wait_drain(3 * G + 50);
            chk("busy_continuous_end", int'(busy), 1);
            reset_n = 1'b0;
            @(negedge clk);
            chk_reset_outputs("reset_stops_continuous");
            reset_n = 1'b1;
        end
`else
        // Period-40 oscillator: nominal 25.6 edges per gate
        run(25, 26, 0);

        // Abort mid-gate, then a clean measurement
        do_start(1'b0, 0, 0, 0);
        repeat (500) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        chk_reset_outputs("abort_outputs");
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        run(25, 26, 0);

        // Period 3 saturates, next period-40 run clears overflow
        osc_half = 15;
        repeat (5) @(negedge clk);
        run(255, 255, 1);
        osc_half = 200;
        repeat (40) @(negedge clk);
        run(25, 26, 0);

        // Constant levels produce no edges
        osc_mode = 1;
        repeat (40) @(negedge clk);
        run(0, 0, 0);
        osc_mode = 2;
        repeat (10) @(negedge clk);
        run(0, 0, 0);
        osc_mode = 0;
        repeat (40) @(negedge clk);

        // Start re-asserted during the gate must be ignored
        do_start(1'b1, 25, 26, 0);
        repeat (300) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_drain(G + 20);
        repeat (G + 20) @(negedge clk);
        chk("busy_after_reassert", int'(busy), 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
